regfile_wb_arbiter: RTL and testbench

Sits directly upstream of the register file write port (rd/rd_din/reg_write).
- Merges two writeback sources into the single write port:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - a long-latency unit (load/mul-div) response, over a valid/ready handshake, buffered in a small FIFO.
- Keeps a pending-register scoreboard and produces the issue-stage stall.
- Produces a one-cycle hold request so the FIFO is never starved.

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - pipeline writeback and long-latency result handshake bundle
interface regfile_wb_arbiter_if #(
   parameter int XLEN = 32
);
   logic            pipe_we_i;
   logic [4:0]      pipe_rd_i;
   logic [XLEN-1:0] pipe_data_i;
   logic            lu_valid_i;
   logic            lu_ready_o;
   logic [4:0]      lu_rd_i;
   logic [XLEN-1:0] lu_data_i;

   modport master (
      output pipe_we_i, pipe_rd_i, pipe_data_i,
      output lu_valid_i, lu_rd_i, lu_data_i,
      input  lu_ready_o
   );

   modport slave (
      input  pipe_we_i, pipe_rd_i, pipe_data_i,
      input  lu_valid_i, lu_rd_i, lu_data_i,
      output lu_ready_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline and long-latency writeback into one register file port
// with a pending-register scoreboard and an anti-starvation hold request.
module regfile_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int LU_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   regfile_wb_arbiter_if.slave wb,
   input  logic                issue_i,
   input  logic [4:0]          issue_rd_i,
   input  logic [4:0]          chk_rs1_i,
   input  logic [4:0]          chk_rs2_i,
   input  logic [4:0]          chk_rd_i,
   output logic                stall_o,
   output logic                hold_o,
   output logic [4:0]          rd_o,
   output logic [XLEN-1:0]     rd_din_o,
   output logic                reg_write_o
);
   localparam int              AW        = $clog2(LU_DEPTH);
   localparam int              CW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(LU_DEPTH);
   localparam logic [CW-1:0]   LAST_CNT  = CW'(STARVE_LIMIT - 1);

   logic [4:0]      fifo_rd   [LU_DEPTH];
   logic [XLEN-1:0] fifo_data [LU_DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [AW:0]     count;
   logic            full;
   logic            empty;
   logic            accept;
   logic            push;
   logic            pop;
   logic            pipe_win;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;
   logic [31:0]     pending;
   logic [31:0]     pending_next;
   logic [31:0]     clear_mask;
   logic [31:0]     pending_eff;
   logic [CW-1:0]   starve_cnt;

   assign count         = wr_ptr - rd_ptr;
   assign full          = (count == DEPTH_CNT);
   assign empty         = (wr_ptr == rd_ptr);
   assign wb.lu_ready_o = !full;
   assign accept        = wb.lu_valid_i && !full;
   // rd=0 results complete the handshake but never occupy a slot
   assign push          = accept && (wb.lu_rd_i != 5'd0);
   assign pipe_win      = wb.pipe_we_i && (wb.pipe_rd_i != 5'd0);
   // during hold the head always drains, even if upstream misbehaves
   assign pop           = !empty && (!pipe_win || hold_o);
   assign head_rd       = fifo_rd[rd_ptr[AW-1:0]];
   assign head_data     = fifo_data[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rd[wr_ptr[AW-1:0]]   <= wb.lu_rd_i;
         fifo_data[wr_ptr[AW-1:0]] <= wb.lu_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW + 1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_o        <= 5'd0;
         rd_din_o    <= '0;
         reg_write_o <= 1'b0;
      end else if (pop) begin
         rd_o        <= head_rd;
         rd_din_o    <= head_data;
         reg_write_o <= 1'b1;
      end else if (pipe_win) begin
         rd_o        <= wb.pipe_rd_i;
         rd_din_o    <= wb.pipe_data_i;
         reg_write_o <= 1'b1;
      end else begin
         reg_write_o <= 1'b0;
      end
   end

   always_comb begin
      clear_mask = '0;
      if (pop) begin
         clear_mask[head_rd] = 1'b1;
      end
   end

   always_comb begin
      pending_next = pending & ~clear_mask;
      if (issue_i && (issue_rd_i != 5'd0)) begin
         pending_next[issue_rd_i] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // the register being drained this cycle no longer blocks issue
   assign pending_eff = pending & ~clear_mask;
   assign stall_o     = pending_eff[chk_rs1_i] | pending_eff[chk_rs2_i] | pending_eff[chk_rd_i];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
         hold_o     <= 1'b0;
      end else begin
         hold_o <= 1'b0;
         if (empty || pop) begin
            starve_cnt <= '0;
         end else if (pipe_win) begin
            if (starve_cnt == LAST_CNT) begin
               starve_cnt <= '0;
               hold_o     <= 1'b1;
            end else begin
               starve_cnt <= starve_cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(issue_i && (issue_rd_i != 5'd0) && pending[issue_rd_i]));
         assert (!(pipe_win && pending[wb.pipe_rd_i]));
         assert (!(wb.pipe_we_i && hold_o));
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic [4:0]  chk_rd;
   logic        stall;
   logic        hold;
   logic [4:0]  rd;
   logic [31:0] rd_din;
   logic        reg_write;

   int          total = 0;
   int          bad   = 0;
   int          nxt;
   logic [4:0]  t3_rd  [3];
   int          t3_acc [3];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.XLEN(32)) wb ();

   regfile_wb_arbiter #(
      .XLEN(32), .LU_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .wb(wb),
      .issue_i(issue), .issue_rd_i(issue_rd),
      .chk_rs1_i(chk_rs1), .chk_rs2_i(chk_rs2), .chk_rd_i(chk_rd),
      .stall_o(stall), .hold_o(hold),
      .rd_o(rd), .rd_din_o(rd_din), .reg_write_o(reg_write)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; issue = 1'b0; issue_rd = '0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
      wb.pipe_we_i = 1'b0; wb.pipe_rd_i = '0; wb.pipe_data_i = '0;
      wb.lu_valid_i = 1'b0; wb.lu_rd_i = '0; wb.lu_data_i = '0;
      t3_rd[0] = 5'd3; t3_rd[1] = 5'd4; t3_rd[2] = 5'd6;
      t3_acc[0] = 0; t3_acc[1] = 1; t3_acc[2] = 6;
      tick(); tick();
      sample();
      chk("rst_we", reg_write, 0);
      chk("rst_rd", rd, 0);
      chk("rst_din", rd_din, 0);
      chk("rst_hold", hold, 0);
      chk("rst_ready", wb.lu_ready_o, 1);
      chk("rst_stall", stall, 0);
      tick();
      rst_n = 1'b1;

      // pipeline write, one cycle latency
      tick();
      wb.pipe_we_i = 1'b1; wb.pipe_rd_i = 5'd5; wb.pipe_data_i = 32'hDEADBEEF;
      tick();
      wb.pipe_we_i = 1'b0;
      sample();
      chk("t1_we", reg_write, 1);
      chk("t1_rd", rd, 5);
      chk("t1_din", rd_din, 32'hDEADBEEF);
      tick();
      sample();
      chk("t1_we_off", reg_write, 0);

      // scoreboard set by issue, cleared by long-latency pop
      tick();
      issue = 1'b1; issue_rd = 5'd7;
      tick();
      issue = 1'b0; chk_rs1 = 5'd7;
      sample();
      chk("t2_stall_set", stall, 1);
      tick();
      wb.lu_valid_i = 1'b1; wb.lu_rd_i = 5'd7; wb.lu_data_i = 32'h1234;
      sample();
      chk("t2_ready", wb.lu_ready_o, 1);
      chk("t2_stall_acc", stall, 1);
      tick();
      wb.lu_valid_i = 1'b0;
      sample();
      chk("t2_stall_pop", stall, 0);
      chk("t2_we_pop", reg_write, 0);
      tick();
      sample();
      chk("t2_we", reg_write, 1);
      chk("t2_rd", rd, 7);
      chk("t2_din", rd_din, 32'h1234);
      chk("t2_stall_after", stall, 0);
      tick();
      chk_rs1 = 5'd0;

      // FIFO fills under continuous pipe writes, drained by hold cycles
      nxt = 0;
      for (int c = 0; c < 18; c++) begin
         wb.pipe_we_i   = !hold;
         wb.pipe_rd_i   = 5'd10;
         wb.pipe_data_i = 32'(c);
         wb.lu_valid_i  = (nxt < 3);
         wb.lu_rd_i     = (nxt < 3) ? t3_rd[nxt] : 5'd0;
         wb.lu_data_i   = (nxt < 3) ? 32'h300 + 32'(t3_rd[nxt]) : 32'h0;
         sample();
         chk($sformatf("t3_hold_c%0d", c), hold, (c == 5 || c == 10 || c == 15) ? 1 : 0);
         case (c)
            1: chk("t3_ready_c1", wb.lu_ready_o, 1);
            2: chk("t3_ready_c2", wb.lu_ready_o, 0);
            5: chk("t3_ready_c5", wb.lu_ready_o, 0);
            6: chk("t3_ready_c6", wb.lu_ready_o, 1);
            7: chk("t3_ready_c7", wb.lu_ready_o, 0);
            default: ;
         endcase
         if (c == 6 || c == 11 || c == 16) begin
            chk($sformatf("t3_we_c%0d", c), reg_write, 1);
            chk($sformatf("t3_rd_c%0d", c), rd, (c == 6) ? 3 : (c == 11) ? 4 : 6);
            chk($sformatf("t3_din_c%0d", c), rd_din, (c == 6) ? 32'h303 : (c == 11) ? 32'h304 : 32'h306);
         end
         if (wb.lu_valid_i && wb.lu_ready_o) begin
            chk($sformatf("t3_acc_rd%0d", t3_rd[nxt]), c, t3_acc[nxt]);
            nxt++;
         end
         tick();
      end
      wb.lu_valid_i = 1'b0;
      chk("t3_all_accepted", nxt, 3);

      // single queued entry starved for STARVE_LIMIT cycles
      for (int c = 0; c < 10; c++) begin
         wb.pipe_we_i   = !hold;
         wb.pipe_rd_i   = 5'd10;
         wb.pipe_data_i = 32'h100 + 32'(c);
         wb.lu_valid_i  = (c == 0);
         wb.lu_rd_i     = 5'd8;
         wb.lu_data_i   = 32'h808;
         sample();
         chk($sformatf("t4_hold_c%0d", c), hold, (c == 5) ? 1 : 0);
         if (c == 6) begin
            chk("t4_rd", rd, 8);
            chk("t4_din", rd_din, 32'h808);
         end
         tick();
      end
      wb.pipe_we_i = 1'b0; wb.lu_valid_i = 1'b0;

      // rd=0 on both sources
      tick();
      wb.pipe_we_i = 1'b1; wb.pipe_rd_i = 5'd10; wb.pipe_data_i = 32'hA;
      wb.lu_valid_i = 1'b1; wb.lu_rd_i = 5'd9; wb.lu_data_i = 32'h909;
      sample();
      chk("t5_ready_c0", wb.lu_ready_o, 1);
      tick();
      wb.pipe_rd_i = 5'd0; wb.pipe_data_i = 32'hBAD;
      wb.lu_rd_i = 5'd0; wb.lu_data_i = 32'hBAD;
      sample();
      chk("t5_ready_c1", wb.lu_ready_o, 1);
      chk("t5_pipe_rd", rd, 10);
      tick();
      wb.pipe_we_i = 1'b0; wb.lu_valid_i = 1'b0;
      sample();
      chk("t5_we9", reg_write, 1);
      chk("t5_rd9", rd, 9);
      chk("t5_din9", rd_din, 32'h909);
      tick();
      sample();
      chk("t5_no_x0", reg_write, 0);
      chk("t5_ready_c3", wb.lu_ready_o, 1);

      // reset while full with pending registers
      tick();
      issue = 1'b1; issue_rd = 5'd3;
      tick();
      issue_rd = 5'd4;
      tick();
      issue = 1'b0; chk_rs1 = 5'd3; chk_rs2 = 5'd4;
      wb.pipe_we_i = 1'b1; wb.pipe_rd_i = 5'd10; wb.pipe_data_i = 32'h55;
      wb.lu_valid_i = 1'b1; wb.lu_rd_i = 5'd3; wb.lu_data_i = 32'h33;
      sample();
      chk("t6_stall_pre", stall, 1);
      tick();
      wb.lu_rd_i = 5'd4; wb.lu_data_i = 32'h44;
      sample();
      chk("t6_ready_2nd", wb.lu_ready_o, 1);
      tick();
      wb.lu_valid_i = 1'b0;
      sample();
      chk("t6_full", wb.lu_ready_o, 0);
      tick();
      rst_n = 1'b0; wb.pipe_we_i = 1'b0;
      tick();
      rst_n = 1'b1;
      sample();
      chk("t6_ready", wb.lu_ready_o, 1);
      chk("t6_stall", stall, 0);
      chk("t6_we", reg_write, 0);
      chk("t6_hold", hold, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         sample();
         chk($sformatf("t6_we_c%0d", c), reg_write, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
